// File: rtl/pipeline_dmem_ctrl_pkg.sv
// Shared pipeline definitions for the M-stage data-memory controller.
package pipeline_dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } dmem_state_t;

    // Bubble instruction used by the pipeline registers (ADD x0,x0,x0).
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0033;
    localparam logic [31:0] DMEM_ERR_DATA = 32'h0000_0000;

endpackage

// File: rtl/pipeline_dmem_ctrl_if.sv
// Data-memory req/gnt/rvalid bus between the M-stage controller and memory.
interface pipeline_dmem_ctrl_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/pipeline_dmem_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module pipeline_dmem_ctrl_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_dmem_ctrl.sv
// M-stage data-memory sequencer: stalls F..M and bubbles M/W while a
// variable-latency access is outstanding, with timeout and stall counting.
module pipeline_dmem_ctrl
    import pipeline_dmem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 MemReadM,
    input  logic                 MemWriteM,
    input  logic [31:0]          ALUResultM,
    input  logic [31:0]          WriteDataM,
    input  logic [3:0]           ByteEnM,
    pipeline_dmem_ctrl_if.master mem,
    output logic [31:0]          ReadData,
    output logic                 StallM,
    output logic                 FlushW,
    output logic                 BusErr,
    output logic [CNT_W-1:0]     StallCnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    dmem_state_t   state;
    logic          access;
    logic [31:0]   data_q;
    logic          bus_err_q;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          tmo_inc;
    logic          tmo_clr;

    assign access = MemReadM | MemWriteM;

    // Bus fields follow the M-stage inputs directly; StallM keeps E/M frozen.
    assign mem.mem_we    = MemWriteM;
    assign mem.mem_addr  = ALUResultM & ~32'h0000_0003;
    assign mem.mem_wdata = WriteDataM;
    assign mem.mem_be    = ByteEnM;

    always_comb begin
        mem.mem_req = 1'b0;
        StallM      = 1'b0;
        FlushW      = 1'b0;
        case (state)
            IDLE: begin
                mem.mem_req = access;
                StallM      = access;
                FlushW      = access;
            end
            REQ: begin
                mem.mem_req = 1'b1;
                StallM      = 1'b1;
                FlushW      = 1'b1;
            end
            WAIT: begin
                StallM = 1'b1;
                FlushW = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign ReadData = (state == DONE) ? data_q : mem.mem_rdata;
    assign BusErr   = bus_err_q;

    // Timeout counter restarts whenever REQ or WAIT is freshly entered.
    assign tmo_inc = (state == REQ) || (state == WAIT);
    assign tmo_clr = ((state == IDLE) && access) || ((state == REQ) && mem.mem_gnt);
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

    pipeline_dmem_ctrl_sat_counter #(.W(TW)) u_tmo_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (tmo_inc),
        .clear (tmo_clr),
        .count (tmo_cnt)
    );

    pipeline_dmem_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (StallM),
        .clear (1'b0),
        .count (StallCnt)
    );

    // Handshake FSM; a real gnt/rvalid in the expiry cycle beats the timeout.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            data_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        state <= mem.mem_gnt ? WAIT : REQ;
                    end
                end
                REQ: begin
                    if (mem.mem_gnt) begin
                        state <= WAIT;
                    end else if (tmo_hit) begin
                        state     <= DONE;
                        bus_err_q <= 1'b1;
                        data_q    <= DMEM_ERR_DATA;
                    end
                end
                WAIT: begin
                    if (mem.mem_rvalid) begin
                        state <= DONE;
                        if (!MemWriteM) begin
                            data_q <= mem.mem_rdata;
                        end
                    end else if (tmo_hit) begin
                        state     <= DONE;
                        bus_err_q <= 1'b1;
                        data_q    <= DMEM_ERR_DATA;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pipeline_dmem_ctrl.md
Name: pipeline_dmem_ctrl

Overview:
- Sequences the M-stage data-memory access of the 5-stage RISC-V pipeline against a variable-latency data memory using a req/gnt/rvalid handshake.
- Freezes stages F..M and injects bubbles into the M/W pipeline register until the access completes.
- Presents the final ReadData to the M/W register for exactly one cycle.
- Adds a timeout/bus-error path and a saturating stall-cycle counter.

Parameters:
TIMEOUT, 16, max cycles spent in REQ+WAIT before forced completion with error (>=2)
CNT_W, 32, width of stall-cycle performance counter

Ports:
clk  input  1  clock
n_rst  input  1  asynchronous active-low reset
MemReadM  input  1  load in M stage
MemWriteM  input  1  store in M stage
ALUResultM  input  32  effective address
WriteDataM  input  32  store data
ByteEnM  input  4  byte enables for store/load
mem_req  output  1  request valid to data memory
mem_we  output  1  1=write, 0=read
mem_addr  output  32  word address (ALUResultM with [1:0] forced 0)
mem_wdata  output  32  store data
mem_be  output  4  byte enables
mem_gnt  input  1  memory accepts request this cycle
mem_rvalid  input  1  response valid (read data or write ack)
mem_rdata  input  32  read data
ReadData  output  32  load data to M/W register
StallM  output  1  hold PC, F/D, D/E, E/M registers
FlushW  output  1  M/W captures bubble (RegWriteW=0, InstrW=NOP 0x0000_0033)
BusErr  output  1  one-cycle pulse on timeout
StallCnt  output  CNT_W  cycles with StallM=1, saturating

Behaviour:
- Reset (async, n_rst=0): state IDLE, timeout counter 0, data register 0, StallCnt 0, BusErr 0. mem_req, StallM and FlushW are 0 because no access is latched. Reset mid-access abandons the transaction; any later rvalid from memory is ignored in IDLE.
- Definition: access = MemReadM | MemWriteM.
- mem_we, mem_addr, mem_wdata and mem_be are driven combinationally from the M-stage inputs. They stay stable during an access because StallM freezes E/M.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - mem_req = access; StallM = access; FlushW = access.
  - access & mem_gnt -> WAIT; access & !mem_gnt -> REQ; else stay in IDLE.
  - With no access, ReadData = mem_rdata pass-through (don't-care); StallM = 0 and FlushW = 0.
- REQ: mem_req=1, StallM=1, FlushW=1. mem_gnt -> WAIT.
- WAIT: mem_req=0, StallM=1, FlushW=1. mem_rvalid -> capture mem_rdata into the data register (reads only; writes leave it unchanged) -> DONE.
- DONE:
  - mem_req=0, StallM=0, FlushW=0; ReadData = data register.
  - The M/W register captures the completed instruction at this edge and the pipeline advances.
  - Next state is IDLE unconditionally. The same instruction never issues twice, because the new M-stage instruction is first seen in IDLE.
- Timeout:
  - The counter clears on entry to REQ or WAIT and increments each cycle spent in REQ or WAIT.
  - When the count reaches TIMEOUT-1 without the exit condition: go to DONE, pulse BusErr=1 for that DONE cycle, and load the data register with 0.
  - gnt or rvalid arriving in the same cycle as expiry wins, and no error is raised.
- mem_rvalid is ignored in IDLE, REQ and DONE. The memory contract is at least one cycle between gnt and rvalid.
- Minimum latency: gnt in the IDLE cycle plus rvalid in the first WAIT cycle gives an M-stage occupancy of 3 cycles, with StallM high for 2 cycles.
- StallCnt increments by 1 on every cycle with StallM=1 and saturates at all-ones.
- Back-to-back accesses: DONE -> IDLE -> new access. There is exactly one non-stalled cycle (DONE) between consecutive accesses.

Decomposition:
- Shared pipeline package holds:
  - dmem_state_t enum {IDLE, REQ, WAIT, DONE}
  - NOP_INSTR = 32'h0000_0033, shared with the pipeline registers
  - DMEM_ERR_DATA = 32'h0
- The optional sub-module is sat_counter (parameterised width, inc and clear), reused for StallCnt and the timeout counter.

Test Plan:
- Load, gnt in IDLE cycle, rvalid after 1 WAIT cycle with rdata=0x1234_5678 -> StallM=1 for 2 cycles; in DONE, ReadData=0x1234_5678, FlushW=0; StallCnt=2.
- Store to addr 0x0000_1003 with be=4'b0011, gnt delayed 3 cycles, ack 2 cycles later -> mem_addr=0x0000_1000 and mem_we=1 held stable while mem_req=1; FlushW=1 for 6 cycles; DONE after that.
- Load, gnt given, rvalid never arrives, TIMEOUT=16 -> DONE entered 16 cycles after WAIT entry; BusErr=1 for one cycle; ReadData=0; FSM returns to IDLE.
- Two consecutive loads returning 0xAAAA_AAAA then 0x5555_5555 -> two separate req phases with exactly one DONE cycle between; each value presented once in its own DONE cycle.
- n_rst asserted during WAIT, rvalid arriving after release -> outputs return to 0 immediately; the stray rvalid is ignored; no DONE occurs.
- No access for 20 cycles -> mem_req=0, StallM=0, FlushW=0 throughout; StallCnt unchanged.
